// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer for the X9 core. It drives the instruction ROM
// address and counts retired instructions between start and halt.
module fetch_ctrl #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          stall,
    input  logic          branch_en,
    input  logic          branch_rel,
    input  logic [D-1:0]  target,
    input  logic          halt,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [D-1:0]  pc_q;
    logic [CW-1:0] retired_q;

    logic [D-1:0]  pc_seq_d;
    logic [D-1:0]  pc_branch_d;
    logic [CW-1:0] retired_inc_d;

    // Both adds stay D bits wide, so the carry drops and the PC wraps modulo 2**D.
    // Relative targets are two's-complement, which makes the same add handle
    // negative offsets.
    assign pc_seq_d      = pc_q + D'(1);
    assign pc_branch_d   = branch_rel ? (pc_q + target) : target;
    assign retired_inc_d = (&retired_q) ? retired_q : retired_q + CW'(1);

    // NOTE: sequential state is updated with non-blocking assignments. Every register
    // then samples its pre-edge value, whatever order the statements appear in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= RUN;
                        pc_q      <= start_addr;
                        retired_q <= '0;
                    end
                end
                RUN: begin
                    if (start) begin
                        pc_q      <= start_addr;
                        retired_q <= '0;
                    end else if (halt) begin
                        state_q   <= DONE;
                        retired_q <= retired_inc_d;
                    end else if (stall) begin
                        // The branch is dropped here. The decoder re-presents it once the stall clears.
                        pc_q      <= pc_q;
                    end else if (branch_en) begin
                        pc_q      <= pc_branch_d;
                        retired_q <= retired_inc_d;
                    end else begin
                        pc_q      <= pc_seq_d;
                        retired_q <= retired_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prog_ctr = pc_q;
    assign retired  = retired_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. A second instance with CW=4 shares all the inputs
// and is used to show that the retired counter saturates.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] start_addr;
    logic        stall;
    logic        branch_en;
    logic        branch_rel;
    logic [11:0] target;
    logic        halt;

    logic [11:0] prog_ctr;
    logic        running;
    logic        done;
    logic [15:0] retired;

    logic [11:0] sat_prog_ctr;
    logic        sat_running;
    logic        sat_done;
    logic [3:0]  sat_retired;

    int n_cmp;
    int n_err;

    fetch_ctrl #(.D(12), .CW(16)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_rel (branch_rel),
        .target     (target),
        .halt       (halt),
        .prog_ctr   (prog_ctr),
        .running    (running),
        .done       (done),
        .retired    (retired)
    );

    fetch_ctrl #(.D(12), .CW(4)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_rel (branch_rel),
        .target     (target),
        .halt       (halt),
        .prog_ctr   (sat_prog_ctr),
        .running    (sat_running),
        .done       (sat_done),
        .retired    (sat_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input logic [11:0] pc, input logic [15:0] ret);
        check({tag, ".pc"}, 32'(prog_ctr), 32'(pc));
        check({tag, ".retired"}, 32'(retired), 32'(ret));
        check({tag, ".running"}, 32'(running), 32'd1);
        check({tag, ".done"}, 32'(done), 32'd0);
    endtask

    task automatic do_start(input logic [11:0] addr);
        start      = 1'b1;
        start_addr = addr;
        step();
        start      = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        stall      = 1'b0;
        branch_en  = 1'b0;
        branch_rel = 1'b0;
        target     = '0;
        halt       = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst.pc", 32'(prog_ctr), 32'h0);
        check("rst.running", 32'(running), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.retired", 32'(retired), 32'd0);

        // In IDLE, everything except start is ignored.
        branch_en = 1'b1;
        target    = 12'h055;
        halt      = 1'b1;
        step();
        branch_en = 1'b0;
        halt      = 1'b0;
        check("idle.pc", 32'(prog_ctr), 32'h0);
        check("idle.running", 32'(running), 32'd0);
        check("idle.done", 32'(done), 32'd0);

        // Reset and start: 0x010 followed by three sequential fetches.
        do_start(12'h010);
        check_run("start0", 12'h010, 16'd0);
        step();
        check_run("seq1", 12'h011, 16'd1);
        step();
        check_run("seq2", 12'h012, 16'd2);
        step();
        check_run("seq3", 12'h013, 16'd3);

        // Absolute branch, then a relative branch of -2.
        do_start(12'h020);
        check_run("br.start", 12'h020, 16'd0);
        branch_en  = 1'b1;
        branch_rel = 1'b0;
        target     = 12'h100;
        step();
        check_run("br.abs", 12'h100, 16'd1);
        branch_rel = 1'b1;
        target     = 12'hFFE;
        step();
        branch_en  = 1'b0;
        branch_rel = 1'b0;
        check_run("br.rel_neg", 12'h0FE, 16'd2);

        // Sequential wrap from 0xFFF, and a relative branch that overflows.
        do_start(12'hFFF);
        check_run("wrap.start", 12'hFFF, 16'd0);
        step();
        check_run("wrap.seq", 12'h000, 16'd1);
        do_start(12'hFF0);
        branch_en  = 1'b1;
        branch_rel = 1'b1;
        target     = 12'h020;
        step();
        branch_en  = 1'b0;
        branch_rel = 1'b0;
        check_run("wrap.rel", 12'h010, 16'd1);

        // A stall takes priority over a pending branch.
        do_start(12'h005);
        stall     = 1'b1;
        branch_en = 1'b1;
        target    = 12'h040;
        step();
        check_run("stall1", 12'h005, 16'd0);
        step();
        check_run("stall2", 12'h005, 16'd0);
        stall = 1'b0;
        step();
        branch_en = 1'b0;
        check_run("stall.release", 12'h040, 16'd1);

        // Halt at 0x030 after five retired instructions.
        do_start(12'h02B);
        repeat (5) step();
        check_run("halt.pre", 12'h030, 16'd5);
        halt = 1'b1;
        step();
        halt = 1'b0;
        branch_en = 1'b1;
        target    = 12'h077;
        for (int i = 0; i < 3; i++) begin
            check("done.flag", 32'(done), 32'd1);
            check("done.running", 32'(running), 32'd0);
            check("done.pc", 32'(prog_ctr), 32'h030);
            check("done.retired", 32'(retired), 32'd6);
            step();
        end
        branch_en = 1'b0;
        do_start(12'h000);
        check_run("restart", 12'h000, 16'd0);

        // When start and halt arrive together, the restart wins.
        start      = 1'b1;
        halt       = 1'b1;
        start_addr = 12'h200;
        step();
        start = 1'b0;
        halt  = 1'b0;
        check_run("start_halt", 12'h200, 16'd0);

        // When stall and halt arrive together, the halt wins and still retires.
        stall = 1'b1;
        halt  = 1'b1;
        step();
        stall = 1'b0;
        halt  = 1'b0;
        check("stall_halt.done", 32'(done), 32'd1);
        check("stall_halt.pc", 32'(prog_ctr), 32'h200);
        check("stall_halt.retired", 32'(retired), 32'd1);

        // Saturation: the CW=4 copy stops at 15 while the CW=16 copy reaches 20.
        do_start(12'h000);
        repeat (20) step();
        check_run("sat.main", 12'h014, 16'd20);
        check("sat.retired", 32'(sat_retired), 32'd15);
        check("sat.pc", 32'(sat_prog_ctr), 32'h014);
        check("sat.running", 32'(sat_running), 32'd1);

        // A mid-run reset overrides a start in the same cycle.
        reset      = 1'b1;
        start      = 1'b1;
        start_addr = 12'h123;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("mrst.pc", 32'(prog_ctr), 32'h0);
        check("mrst.running", 32'(running), 32'd0);
        check("mrst.done", 32'(done), 32'd0);
        check("mrst.retired", 32'(retired), 32'd0);
        check("mrst.sat_done", 32'(sat_done), 32'd0);
        step();
        check("mrst.idle_pc", 32'(prog_ctr), 32'h0);
        check("mrst.idle_running", 32'(running), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
